// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions: fetch FSM encoding, bubble encoding and PC helpers.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Sequential PC; 32-bit modulo so 32'hFFFF_FFFC wraps to 0.
    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register with write enable, flush and bubble insert.
// Flush wins over everything (including a deasserted write enable); bubble applies only on write.
module ifid_reg
    import fetch_stage_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          write_en,
    input  logic          flush,
    input  logic          bubble,
    input  logic [DW-1:0] instr_in,
    input  logic [DW-1:0] pc4_in,
    output logic [DW-1:0] instr,
    output logic [DW-1:0] pc4,
    output logic          valid
);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            instr <= DW'(NOP_INSTR);
            pc4   <= '0;
            valid <= 1'b0;
        end else if (write_en) begin
            if (bubble) begin
                instr <= DW'(NOP_INSTR);
                pc4   <= '0;
                valid <= 1'b0;
            end else begin
                instr <= instr_in;
                pc4   <= pc4_in;
                valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, imem request FSM (FETCH/HOLD/DRAIN) and IF/ID register.
// Accepts 1 instr/cycle on zero-wait memory; hazard holds park a returned word in a buffer.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pc_write,
    input  logic             ifid_write,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    input  logic             jump,
    input  logic [31:0]      jump_target,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    input  logic             imem_ready,
    output logic [31:0]      ifid_instr,
    output logic [31:0]      ifid_pc4,
    output logic             ifid_valid,
    output logic             fetch_stall,
    output logic [CNT_W-1:0] stall_count
);

    fetch_state_t state, state_nxt;

    logic [31:0]      pc_q;
    logic [31:0]      hold_buf;
    logic [31:0]      drain_tgt;
    logic [CNT_W-1:0] stall_q;

    logic        redirect;
    logic [31:0] redirect_pc;
    logic        hold;

    logic        pc_ld;
    logic [31:0] pc_d;
    logic        buf_ld;
    logic        tgt_ld;
    logic        ifid_we;
    logic        ifid_flush;
    logic        ifid_bubble;
    logic [31:0] ifid_src;

    // Branch is the older instruction, so it beats a simultaneous jump.
    assign redirect    = branch_taken | jump;
    assign redirect_pc = branch_taken ? branch_target : jump_target;
    assign hold        = !(pc_write && ifid_write);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_ld       = 1'b0;
        pc_d        = pc_q;
        buf_ld      = 1'b0;
        tgt_ld      = 1'b0;
        ifid_we     = 1'b0;
        ifid_flush  = 1'b0;
        ifid_bubble = 1'b0;
        ifid_src    = imem_rdata;
        case (state)
            ST_FETCH: begin
                if (imem_ready) begin
                    if (redirect) begin
                        pc_ld      = 1'b1;
                        pc_d       = redirect_pc;
                        ifid_flush = 1'b1;
                    end else if (!hold) begin
                        pc_ld   = 1'b1;
                        pc_d    = pc_next(pc_q);
                        ifid_we = 1'b1;
                    end else begin
                        buf_ld    = 1'b1;
                        state_nxt = ST_HOLD;
                    end
                end else if (redirect) begin
                    // Request already on the bus must complete before the target is fetched.
                    tgt_ld     = 1'b1;
                    ifid_flush = 1'b1;
                    state_nxt  = ST_DRAIN;
                end else if (ifid_write) begin
                    ifid_we     = 1'b1;
                    ifid_bubble = 1'b1;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    pc_ld      = 1'b1;
                    pc_d       = redirect_pc;
                    ifid_flush = 1'b1;
                    state_nxt  = ST_FETCH;
                end else if (!hold) begin
                    pc_ld     = 1'b1;
                    pc_d      = pc_next(pc_q);
                    ifid_we   = 1'b1;
                    ifid_src  = hold_buf;
                    state_nxt = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (imem_ready) begin
                    pc_ld      = 1'b1;
                    pc_d       = redirect ? redirect_pc : drain_tgt;
                    ifid_flush = 1'b1;
                    state_nxt  = ST_FETCH;
                end else if (redirect) begin
                    tgt_ld = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_FETCH;
            end
        endcase
    end

    always_comb begin
        imem_addr   = pc_q;
        imem_req    = !rst && (state != ST_HOLD);
        fetch_stall = !rst && (((state == ST_FETCH) && !imem_ready) || (state == ST_DRAIN));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            hold_buf  <= '0;
            drain_tgt <= '0;
            stall_q   <= '0;
        end else begin
            if (pc_ld) begin
                pc_q <= pc_d;
            end
            if (buf_ld) begin
                hold_buf <= imem_rdata;
            end
            if (tgt_ld) begin
                drain_tgt <= redirect_pc;
            end
            if (!pc_write && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

    assign stall_count = stall_q;

    ifid_reg #(
        .DW (32)
    ) u_ifid_reg (
        .clk      (clk),
        .rst      (rst),
        .write_en (ifid_we),
        .flush    (ifid_flush),
        .bubble   (ifid_bubble),
        .instr_in (ifid_src),
        .pc4_in   (pc_next(pc_q)),
        .instr    (ifid_instr),
        .pc4      (ifid_pc4),
        .valid    (ifid_valid)
    );

endmodule
